// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter for four requesters sharing a 4:1 single-bit mux channel.
// Grants one requester at a time, drives the mux select, and registers the selected bit.
module rr_mux4_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] din,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       dout,
    output logic       dout_vld,
    output logic       busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state, state_nx;
    logic [1:0]        ptr, ptr_nx, sel_nx;
    logic [3:0]        gnt_nx, owner_bit, others, cand;
    logic [HOLD_W-1:0] cnt, cnt_nx;
    logic              do_arb, vld_nx, dout_nx;
    logic [2:0]        win;

    // Returns {found, index}; searches ptr+1, ptr+2, ptr+3, ptr (mod 4).
    function automatic logic [2:0] arb(input logic [3:0] m, input logic [1:0] p);
        logic [2:0] r;
        logic [1:0] i;
        r = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            i = p + 2'(k);
            if (m[i]) r = {1'b1, i};
        end
        return r;
    endfunction

    assign owner_bit = 4'b0001 << sel;
    assign others    = req & ~owner_bit;
    assign win       = arb(cand, ptr);
    assign busy      = (state == GRANT);

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        sel_nx   = sel;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        do_arb   = 1'b0;
        cand     = req;
        case (state)
            IDLE: begin
                gnt_nx = 4'b0000;
                if (|req) do_arb = 1'b1;
            end
            GRANT: begin
                if (!req[sel]) begin
                    if (|others) begin
                        do_arb = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        gnt_nx   = 4'b0000;
                    end
                end else if (cnt == HOLD_W'(MAX_HOLD) && |others) begin
                    // Hold limit reached under contention: current owner sits this round out.
                    cand   = others;
                    do_arb = 1'b1;
                end else if (cnt < HOLD_W'(MAX_HOLD)) begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (do_arb) begin
            state_nx = GRANT;
            gnt_nx   = 4'b0001 << win[1:0];
            sel_nx   = win[1:0];
            ptr_nx   = win[1:0];
            cnt_nx   = HOLD_W'(1);
        end
        vld_nx  = (state == GRANT) && req[sel];
        dout_nx = vld_nx && din[sel];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            sel      <= 2'b00;
            ptr      <= 2'b11;
            cnt      <= '0;
            dout     <= 1'b0;
            dout_vld <= 1'b0;
        end else begin
            state    <= state_nx;
            gnt      <= gnt_nx;
            sel      <= sel_nx;
            ptr      <= ptr_nx;
            cnt      <= cnt_nx;
            dout     <= dout_nx;
            dout_vld <= vld_nx;
        end
    end

endmodule

// File: doc/rr_mux4_arbiter.md
Name: rr_mux4_arbiter

Overview:
Round-robin arbiter that shares the 4:1 single-bit mux channel (din[3:0] -> dout under sel[1:0]) between four requesters. It grants one requester at a time, drives the mux select, and registers the selected bit with a valid flag. A hold limit prevents any requester from monopolising the channel under contention. It sits in front of the existing mux4x1 datapath and replaces fixed, testbench-driven select sequencing.

Parameters:
MAX_HOLD, 4, max consecutive grant cycles for one requester while another requester is pending (legal 1..7)
HOLD_W, 3, width of the hold counter; must hold MAX_HOLD

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
req  input  4  request per requester; bit i = requester i
din  input  4  data bit per requester; bit i belongs to requester i
gnt  output 4  one-hot grant, registered; 0000 when idle
sel  output 2  mux select = index of granted requester, registered
dout output 1  registered selected data bit
dout_vld output 1  registered; dout carries valid data from the granted requester
busy output 1  high while in GRANT state (equals |gnt)

Behaviour:
- Reset (rst=1 at edge): state=IDLE, gnt=0000, sel=00, dout=0, dout_vld=0, busy=0, hold cnt=0, priority pointer ptr=11 (requester 0 wins first). Reset overrides all other activity; mid-grant reset aborts the grant at that edge.
- Arbitration function: search order ptr+1, ptr+2, ptr+3, ptr (mod 4) over the candidate request mask; first set bit wins. Winning index w: gnt<=onehot(w), sel<=w, ptr<=w, cnt<=1.
- IDLE: if req!=0, arbitrate over req and go to GRANT at the next edge (1-cycle request-to-grant latency). Otherwise stay in IDLE; sel holds its last value (no select toggling); gnt=0000.
- GRANT, owner s=sel:
  - req[s]=0 (release): if req has other bits set, arbitrate at this edge (search starts at s+1), with no idle bubble. Otherwise go to IDLE: gnt<=0000, sel unchanged, ptr=s.
  - req[s]=1, cnt==MAX_HOLD, other req bits set: rotate. Arbitrate over req with bit s masked, cnt<=1.
  - req[s]=1 otherwise: hold grant; cnt<=min(cnt+1, MAX_HOLD). Without contention the grant is held indefinitely.
- Data path at every edge: dout_vld<=(state==GRANT && req[sel]); dout<=dout_vld_next ? din[sel] : 0. dout/dout_vld lag the granted cycle by exactly 1 clock.
- Simultaneous release and new request from the same requester: the release is evaluated first. If the requester reasserts in the next cycle, it competes normally from the new pointer.
- MAX_HOLD=1: under full contention, the grant rotates every cycle.
- Exactly one gnt bit is high or none; gnt is never multi-hot. busy==|gnt at all times.

Test Plan:
1. rst=1 for 2 cycles with req=1111, din=1111 -> gnt=0000, sel=00, dout=0, dout_vld=0, busy=0 throughout; first edge after rst=0 -> gnt=0001, sel=00.
2. Single requester: req=1000, din=1000 -> next edge gnt=1000, sel=11, busy=1; following edge dout=1, dout_vld=1; held for 20 cycles (no rotation); req=0000 -> next edge gnt=0000, busy=0, sel stays 11, then dout_vld=0.
3. Full contention from reset, MAX_HOLD=4, req=1111 held -> gnt 0001 for 4 cycles, 0010 for 4, 0100 for 4, 1000 for 4, then 0001 again; sel 00,01,10,11,00.
4. Early release: req=0101, requester 0 granted; drop req[0] after 2 grant cycles -> next edge gnt=0100, sel=10, busy stays 1 (no idle cycle).
5. Data path with gnt=0100 (sel=10), req[2]=1: din=0010, 1011, 0101 on successive cycles -> dout=0, 0, 1 one cycle later each, dout_vld=1.
6. Reset mid-grant: gnt=0100 with cnt=2, assert rst for 1 cycle -> next edge all outputs at reset values. Release rst with req=0101 -> gnt=0001 (ptr reset to 11), not 0100.
